// File: rtl/lockout_if.sv
// Bundle between the lock FSM and its brute-force guard: check results and entry
// requests in, entry grant plus lockout status out to the lock FSM and SSD/LED path.
interface lockout_if #(
  parameter int REM_W = 10
);
  logic             tick;
  logic             chk_valid;
  logic             chk_ok;
  logic             entry_req;
  logic             entry_gnt;
  logic             lockout;
  logic [REM_W-1:0] remain;
  logic [3:0]       fail_cnt;
  logic [1:0]       level;
  logic             alarm;

  modport master (
    output tick, chk_valid, chk_ok, entry_req,
    input  entry_gnt, lockout, remain, fail_cnt, level, alarm
  );

  modport slave (
    input  tick, chk_valid, chk_ok, entry_req,
    output entry_gnt, lockout, remain, fail_cnt, level, alarm
  );
endinterface

// File: rtl/lockout_ctrl.sv
// Brute-force guard for the 4-digit lock: counts consecutive failed checks and
// enforces a tick-timed lockout whose length doubles per escalation level (max 3).
module lockout_ctrl #(
  parameter int MAX_TRIES = 3,
  parameter int LOCK_SECS = 10,
  parameter int REM_W     = 10
) (
  input  logic    clk,
  input  logic    rst,
  lockout_if.slave bus
);

  typedef enum logic [1:0] {
    READY   = 2'b01,
    LOCKOUT = 2'b10
  } state_t;

  localparam logic [3:0]       MAX_T = 4'(MAX_TRIES);
  localparam logic [REM_W-1:0] BASE  = REM_W'(LOCK_SECS);
  localparam logic [REM_W-1:0] ONE   = {{(REM_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic             entry_gnt_r;
  logic             lockout_r;
  logic             alarm_r;
  logic [REM_W-1:0] remain_r;
  logic [3:0]       fail_cnt_r;
  logic [1:0]       level_r;
  logic [3:0]       fail_nxt_s;
  logic             trip_s;

  function automatic logic [1:0] level_inc(input logic [1:0] lv);
    return (lv == 2'd3) ? 2'd3 : lv + 2'd1;
  endfunction

  assign fail_nxt_s = fail_cnt_r + 4'd1;
  assign trip_s     = bus.chk_valid & ~bus.chk_ok & (fail_nxt_s >= MAX_T);

  // Guard FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= READY;
      entry_gnt_r <= 1'b0;
      lockout_r   <= 1'b0;
      alarm_r     <= 1'b0;
      remain_r    <= '0;
      fail_cnt_r  <= 4'd0;
      level_r     <= 2'd0;
    end else begin
      case (state_r)
        READY: begin
          alarm_r <= 1'b0;
          if (trip_s) begin
            // Remain uses the pre-escalation level; a same-edge request is dropped.
            state_r     <= LOCKOUT;
            lockout_r   <= 1'b1;
            alarm_r     <= 1'b1;
            entry_gnt_r <= 1'b0;
            remain_r    <= BASE << level_r;
            level_r     <= level_inc(level_r);
            fail_cnt_r  <= 4'd0;
          end else begin
            entry_gnt_r <= bus.entry_req;
            lockout_r   <= 1'b0;
            remain_r    <= '0;
            if (bus.chk_valid) begin
              if (bus.chk_ok) begin
                fail_cnt_r <= 4'd0;
                level_r    <= 2'd0;
              end else begin
                fail_cnt_r <= fail_nxt_s;
              end
            end
          end
        end
        LOCKOUT: begin
          entry_gnt_r <= 1'b0;
          alarm_r     <= 1'b0;
          fail_cnt_r  <= 4'd0;
          if (bus.tick) begin
            if (remain_r > ONE) begin
              remain_r <= remain_r - ONE;
            end else begin
              remain_r  <= '0;
              lockout_r <= 1'b0;
              state_r   <= READY;
            end
          end
        end
        default: begin
          state_r     <= READY;
          entry_gnt_r <= 1'b0;
          lockout_r   <= 1'b0;
          alarm_r     <= 1'b0;
          remain_r    <= '0;
          fail_cnt_r  <= 4'd0;
        end
      endcase
    end
  end

  assign bus.entry_gnt = entry_gnt_r;
  assign bus.lockout   = lockout_r;
  assign bus.alarm     = alarm_r;
  assign bus.remain    = remain_r;
  assign bus.fail_cnt  = fail_cnt_r;
  assign bus.level     = level_r;

endmodule

// File: tb/tb_lockout_ctrl.sv
// Scoreboard bench for lockout_ctrl: directed steps push hand-computed output vectors,
// a monitor pops and compares one entry each time the DUT output vector changes.
module tb_lockout_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  lockout_if #(.REM_W(10)) bus ();

  lockout_ctrl #(.MAX_TRIES(3), .LOCK_SECS(10), .REM_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Packed view: {gnt, lockout, remain[9:0], fail_cnt[3:0], level[1:0], alarm}
  logic [18:0] exp_q[$];
  logic [18:0] last_exp = '0;
  logic [18:0] prev_vec = '0;
  logic [18:0] cur_vec;
  logic [18:0] got;

  function automatic logic [18:0] ev(input logic g, input logic lo, input logic [9:0] rem,
                                     input logic [3:0] fc, input logic [1:0] lv, input logic al);
    return {g, lo, rem, fc, lv, al};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {bus.entry_gnt, bus.lockout, bus.remain, bus.fail_cnt, bus.level, bus.alarm};
  endfunction

  task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h (gnt lo rem fc lv al: %0b %0b %0d %0d %0d %0b)",
               name, act, exp, act[18], act[17], act[16:7], act[6:3], act[2:1], act[0]);
    end
  endtask

  // Monitor: compare on every change of the output vector.
  always begin
    @(posedge clk);
    #1;
    cur_vec = dut_vec();
    if (cur_vec !== prev_vec) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change act=%h exp=none", cur_vec);
      end else begin
        got = exp_q.pop_front();
        chk("out_vec", cur_vec, got);
      end
    end
    prev_vec = cur_vec;
  end

  task automatic step(input logic req, input logic cv, input logic ok, input logic tk,
                      input logic [18:0] exp);
    @(negedge clk);
    bus.entry_req = req;
    bus.chk_valid = cv;
    bus.chk_ok    = ok;
    bus.tick      = tk;
    @(posedge clk);
    if (exp !== last_exp) begin
      exp_q.push_back(exp);
      last_exp = exp;
    end
  endtask

  task automatic trip(input logic [9:0] rem, input logic [1:0] lv_in, input logic [1:0] lv_out);
    step(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b0, 10'd0, 4'd1, lv_in, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b0, 10'd0, 4'd2, lv_in, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b1, rem, 4'd0, lv_out, 1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b1, rem, 4'd0, lv_out, 1'b0));
  endtask

  task automatic drain(input int n, input logic [1:0] lv);
    for (int i = 1; i < n; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, ev(1'b0, 1'b1, 10'(n - i), 4'd0, lv, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1, ev(1'b0, 1'b0, 10'd0, 4'd0, lv, 1'b0));
  endtask

  initial begin
    bus.entry_req = 1'b0;
    bus.chk_valid = 1'b0;
    bus.chk_ok    = 1'b0;
    bus.tick      = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", dut_vec(), 19'd0);
    @(negedge clk);
    bus.tick = 1'b0;
    rst = 1'b1;

    // Grant one cycle after request, then back to idle.
    step(1'b1, 1'b0, 1'b0, 1'b0, ev(1'b1, 1'b0, 10'd0, 4'd0, 2'd0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 10'd0, 4'd0, 2'd0, 1'b0));

    // First lockout, requests/checks ignored while locked, then timed release.
    trip(10'd10, 2'd0, 2'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b1, 10'd10, 4'd0, 2'd1, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b1, 10'd10, 4'd0, 2'd1, 1'b0));
    step(1'b0, 1'b1, 1'b1, 1'b0, ev(1'b0, 1'b1, 10'd10, 4'd0, 2'd1, 1'b0));
    drain(10, 2'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, ev(1'b0, 1'b0, 10'd0, 4'd0, 2'd1, 1'b0));

    // Escalation: 20, 40, then 80 with level saturated at 3.
    trip(10'd20, 2'd1, 2'd2);
    drain(20, 2'd2);
    trip(10'd40, 2'd2, 2'd3);
    drain(40, 2'd3);
    trip(10'd80, 2'd3, 2'd3);
    drain(80, 2'd3);

    // A success clears level; the next trip loads the base length again.
    step(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b0, 10'd0, 4'd1, 2'd3, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b0, 10'd0, 4'd2, 2'd3, 1'b0));
    step(1'b0, 1'b1, 1'b1, 1'b0, ev(1'b0, 1'b0, 10'd0, 4'd0, 2'd0, 1'b0));
    trip(10'd10, 2'd0, 2'd1);
    drain(10, 2'd1);

    // Third failure coincident with a request: no grant.
    step(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b0, 10'd0, 4'd1, 2'd1, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b0, 10'd0, 4'd2, 2'd1, 1'b0));
    step(1'b1, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b1, 10'd20, 4'd0, 2'd2, 1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b1, 10'd20, 4'd0, 2'd2, 1'b0));
    for (int i = 1; i <= 15; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, ev(1'b0, 1'b1, 10'(20 - i), 4'd0, 2'd2, 1'b0));

    // Asynchronous abort mid-lockout at remain=5.
    #3;
    bus.tick = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_reset", dut_vec(), 19'd0);
    exp_q.push_back(19'd0);
    last_exp = 19'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Back in READY: request with a successful check still grants.
    step(1'b1, 1'b0, 1'b0, 1'b0, ev(1'b1, 1'b0, 10'd0, 4'd0, 2'd0, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b0, ev(1'b0, 1'b0, 10'd0, 4'd1, 2'd0, 1'b0));
    step(1'b1, 1'b1, 1'b1, 1'b0, ev(1'b1, 1'b0, 10'd0, 4'd0, 2'd0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 10'd0, 4'd0, 2'd0, 1'b0));

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_empty act=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
